// File: rtl/channel_triangle_voice_pkg.sv
// channel_voice_pkg: waveform and FSM encodings plus default widths shared by the voice channels.
package channel_voice_pkg;
    localparam logic [1:0] MODE_TRIANGLE = 2'd0;
    localparam logic [1:0] MODE_SAW      = 2'd1;
    localparam logic [1:0] MODE_SQUARE   = 2'd2;
    typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;
    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_AMP_BITS    = 4;
    localparam int DEF_OUT_WIDTH   = 9;
    localparam int DEF_LEN_WIDTH   = 8;
endpackage

// File: rtl/channel_triangle_voice_if.sv
// channel_triangle_voice_if: sequencer-facing note controls and PWM-facing sample outputs of one voice.
interface channel_triangle_voice_if
    import channel_voice_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH
);
    logic                   i_note_on;
    logic                   i_note_off;
    logic [1:0]             i_mode;
    logic [LEN_WIDTH-1:0]   i_length;
    logic [PHASE_WIDTH-1:0] i_phase_delta;
    logic                   i_phase_delta_valid;
    logic                   i_tick;
    logic [OUT_WIDTH-1:0]   o_output;
    logic                   o_frame_pulse;
    logic                   o_active;
    modport master (
        output i_note_on, i_note_off, i_mode, i_length, i_phase_delta, i_phase_delta_valid, i_tick,
        input  o_output, o_frame_pulse, o_active
    );
    modport slave (
        input  i_note_on, i_note_off, i_mode, i_length, i_phase_delta, i_phase_delta_valid, i_tick,
        output o_output, o_frame_pulse, o_active
    );
endinterface

// File: rtl/channel_triangle_voice_wave_shaper.sv
// wave_shaper: combinational phase-to-amplitude mapping (triangle, sawtooth, square) for any channel.
module wave_shaper
    import channel_voice_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int AMP_BITS    = DEF_AMP_BITS
)(
    input  logic [PHASE_WIDTH-1:0] i_phase,
    input  logic [1:0]             i_mode,
    output logic [AMP_BITS-1:0]    o_sample
);
    logic                            w_msb;
    logic [AMP_BITS-1:0]             w_tri;
    logic [AMP_BITS-1:0]             w_saw;
    logic [AMP_BITS-1:0]             w_sqr;
    logic [PHASE_WIDTH-AMP_BITS-2:0] w_unused;
    assign w_msb    = i_phase[PHASE_WIDTH-1];
    assign w_tri    = w_msb ? ~i_phase[PHASE_WIDTH-2 -: AMP_BITS] : i_phase[PHASE_WIDTH-2 -: AMP_BITS];
    assign w_saw    = i_phase[PHASE_WIDTH-1 -: AMP_BITS];
    assign w_sqr    = {AMP_BITS{~w_msb}};
    assign w_unused = i_phase[PHASE_WIDTH-AMP_BITS-2:0];
    // Mode 3 is unassigned and falls back to triangle.
    assign o_sample = (i_mode == MODE_SAW) ? w_saw : (i_mode == MODE_SQUARE) ? w_sqr : w_tri;
endmodule

// File: rtl/channel_triangle_voice.sv
// channel_triangle_voice: note FSM, length counter, clearable phase accumulator and shaped PWM sample.
// Define TRIANGLE_ULTRASONIC_MUTE_EN to freeze the voice while the phase delta is at or above ULTRA_DELTA.
module channel_triangle_voice
    import channel_voice_pkg::*;
#(
    parameter int                     PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int                     AMP_BITS    = DEF_AMP_BITS,
    parameter int                     OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int                     LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter logic [PHASE_WIDTH-1:0] ULTRA_DELTA = PHASE_WIDTH'(32'h4000_0000)
)(
    input logic                     i_clk,
    input logic                     i_reset,
    channel_triangle_voice_if.slave voice
);
    state_t                 r_state;
    state_t                 w_next;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [PHASE_WIDTH-1:0] r_delta;
    logic [PHASE_WIDTH-1:0] w_sum;
    logic                   w_carry;
    logic                   w_mute;
    logic                   w_run;
    logic                   w_expire;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_sustain;
    logic [1:0]             r_mode;
    logic                   r_frame;
    logic [AMP_BITS-1:0]    w_wave;
    logic [OUT_WIDTH-1:0]   r_output;

`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
    assign w_mute = r_delta >= ULTRA_DELTA;
`else
    logic [PHASE_WIDTH-1:0] w_unused_ultra;
    assign w_unused_ultra = ULTRA_DELTA;
    assign w_mute         = 1'b0;
`endif

    assign {w_carry, w_sum} = {1'b0, r_phase} + {1'b0, r_delta};
    assign w_run            = (r_state == ST_PLAY) && !w_mute;
    assign w_expire         = voice.i_tick && !r_sustain && (r_len == LEN_WIDTH'(1));

    wave_shaper #(.PHASE_WIDTH(PHASE_WIDTH), .AMP_BITS(AMP_BITS)) u_shaper (
        .i_phase  (r_phase),
        .i_mode   (r_mode),
        .o_sample (w_wave)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (voice.i_note_on) w_next = ST_PLAY;
        else if (r_state == ST_PLAY && (voice.i_note_off || w_expire)) w_next = ST_IDLE;
    end

    // Output only refreshes while running so a stopped or muted voice holds its level without a click.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase   <= '0;
            r_delta   <= '0;
            r_len     <= '0;
            r_sustain <= 1'b0;
            r_mode    <= MODE_TRIANGLE;
            r_frame   <= 1'b0;
            r_output  <= '0;
        end else begin
            if (voice.i_phase_delta_valid) r_delta <= voice.i_phase_delta;
            r_frame <= w_run && !voice.i_note_on && w_carry;
            if (w_run) r_output <= OUT_WIDTH'(w_wave);
            if (voice.i_note_on) begin
                r_phase   <= '0;
                r_mode    <= voice.i_mode;
                r_len     <= voice.i_length;
                r_sustain <= (voice.i_length == '0);
            end else if (r_state == ST_PLAY) begin
                if (!w_mute) r_phase <= w_sum;
                if (voice.i_tick && !r_sustain && r_len != '0) r_len <= r_len - LEN_WIDTH'(1);
            end
        end
    end

    assign voice.o_output      = r_output;
    assign voice.o_frame_pulse = r_frame;
    assign voice.o_active      = (r_state == ST_PLAY);
endmodule

// File: tb/tb_channel_triangle_voice.sv
// tb_channel_triangle_voice: scoreboard bench for the voice; expected samples are queued at note start.
module tb_channel_triangle_voice;
    typedef struct {
        string      tag;
        logic [8:0] out;
        logic       frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [3:0] tri_tab [16] = '{0, 2, 4, 6, 8, 10, 12, 14, 15, 13, 11, 9, 7, 5, 3, 1};

    always #5 clk = ~clk;

    channel_triangle_voice_if bus ();
    channel_triangle_voice dut (.i_clk(clk), .i_reset(rst), .voice(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic void push(input string tag, input logic [8:0] out, input logic frame);
        exp_t e;
        e.tag   = tag;
        e.out   = out;
        e.frame = frame;
        sb.push_back(e);
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            chk({e.tag, "_out"}, 32'(bus.o_output), 32'(e.out));
            chk({e.tag, "_frame"}, 32'(bus.o_frame_pulse), 32'(e.frame));
        end
    endtask

    task automatic start(input logic [1:0] mode, input logic [7:0] len, input logic [31:0] delta);
        bus.i_note_on           = 1'b1;
        bus.i_mode              = mode;
        bus.i_length            = len;
        bus.i_phase_delta       = delta;
        bus.i_phase_delta_valid = 1'b1;
        @(negedge clk);
        bus.i_note_on           = 1'b0;
        bus.i_phase_delta_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.i_note_on = 0; bus.i_note_off = 0; bus.i_mode = 0; bus.i_length = 0;
        bus.i_phase_delta = 0; bus.i_phase_delta_valid = 0; bus.i_tick = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(bus.o_output), 0);
        chk("rst_frame", 32'(bus.o_frame_pulse), 0);
        chk("rst_active", 32'(bus.o_active), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_active", 32'(bus.o_active), 0);

        start(2'd0, 8'd0, 32'h1000_0000);
        for (int k = 0; k < 32; k++) push("tri", 9'(tri_tab[k % 16]), k % 16 == 15);
        drain();
        chk("tri_active", 32'(bus.o_active), 1);

        start(2'd1, 8'd0, 32'h1000_0000);
        for (int k = 0; k < 32; k++) push("saw", 9'(k % 16), k % 16 == 15);
        drain();

        start(2'd2, 8'd0, 32'h1000_0000);
        for (int k = 0; k < 32; k++) push("sqr", (k % 16 < 8) ? 9'd15 : 9'd0, k % 16 == 15);
        drain();

        start(2'd3, 8'd0, 32'h1000_0000);
        for (int k = 0; k < 16; k++) push("mode3", 9'(tri_tab[k]), k == 15);
        drain();

        // Glide: delta retuned one cycle after note_on, phase keeps running.
        bus.i_note_on = 1; bus.i_mode = 0; bus.i_length = 0;
        bus.i_phase_delta = 32'h1000_0000; bus.i_phase_delta_valid = 1;
        @(negedge clk);
        bus.i_note_on = 0; bus.i_phase_delta = 32'h0800_0000;
        for (int m = 2; m <= 41; m++) begin
            int u;
            u = (m == 2) ? 0 : (m - 1) % 32;
            push("glide", (u < 16) ? 9'(u) : 9'(31 - u), m % 32 == 0);
        end
        drain();
        bus.i_phase_delta_valid = 0;

        start(2'd0, 8'd3, 32'h1000_0000);
        for (int c = 2; c <= 66; c++) begin
            @(negedge clk);
            if (c == 21 || c == 41 || c == 60) chk("len_active", 32'(bus.o_active), 1);
            if (c == 61) chk("len_expire", 32'(bus.o_active), 0);
            if (c >= 61) chk("len_hold", 32'(bus.o_output), 9);
            bus.i_tick = (c == 20 || c == 40 || c == 60);
        end
        bus.i_tick = 0;

        start(2'd0, 8'd0, 32'h0);
        for (int k = 0; k < 20; k++) push("zero_delta", 9'd0, 1'b0);
        drain();

        bus.i_note_off = 1;
        @(negedge clk);
        bus.i_note_off = 0;
        chk("off_idle", 32'(bus.o_active), 0);

        bus.i_note_on = 1; bus.i_note_off = 1; bus.i_length = 0;
        @(negedge clk);
        bus.i_note_on = 0; bus.i_note_off = 0;
        chk("on_off_play", 32'(bus.o_active), 1);

        start(2'd0, 8'd1, 32'h1000_0000);
        bus.i_tick = 1; bus.i_note_on = 1;
        @(negedge clk);
        bus.i_note_on = 0;
        chk("on_tick_play", 32'(bus.o_active), 1);
        @(negedge clk);
        bus.i_tick = 0;
        chk("tick_expire", 32'(bus.o_active), 0);

        start(2'd0, 8'd5, 32'h1000_0000);
        bus.i_note_off = 1; bus.i_tick = 1;
        @(negedge clk);
        bus.i_note_off = 0; bus.i_tick = 0;
        chk("off_tick_idle", 32'(bus.o_active), 0);

        bus.i_note_on = 1; bus.i_mode = 1; bus.i_length = 0;
        bus.i_phase_delta = 32'h1000_0000; bus.i_phase_delta_valid = 1;
        @(negedge clk);
        bus.i_note_on = 0; bus.i_phase_delta = 32'h5000_0000;
        for (int m = 2; m <= 20; m++) begin
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
            push("mute", 9'd0, 1'b0);
`else
            int u;
            u = (m == 2) ? 0 : (1 + 5 * (m - 3)) % 16;
            push("ultra", 9'(u), (m >= 3) && (u + 5 >= 16));
`endif
        end
        drain();
        bus.i_phase_delta_valid = 0;

        start(2'd0, 8'd0, 32'h1000_0000);
        repeat (4) @(negedge clk);
        chk("pre_rst_out", 32'(bus.o_output), 6);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(bus.o_output), 0);
        chk("async_rst_active", 32'(bus.o_active), 0);
        chk("async_rst_frame", 32'(bus.o_frame_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_active", 32'(bus.o_active), 0);
        chk("post_rst_out", 32'(bus.o_output), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
